poly_mult_ctrl: RTL and testbench

Operand sequencer and result collector that sits directly upstream of the negacyclic poly-mult systolic array.
- Accepts the coefficients of operands a and b as a serial valid/ready stream.
- Drives them as stable D*N-bit vectors onto the array's horz/vert inputs and waits the array's fixed pipeline latency.
- Captures the D*N-bit product p and streams it out one coefficient per handshake.

---
 rtl/poly_mult_pkg.sv | 21 ++
 rtl/poly_coef_deser.sv | 33 +++
 rtl/poly_mult_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_poly_mult_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_mult_pkg.sv
// Shared definitions for the negacyclic poly-mult operand sequencer:
// state encodings, default geometry and a coefficient-slice helper.
package poly_mult_pkg;

    localparam int D_DEF   = 4;
    localparam int N_DEF   = 4;
    localparam int LAT_DEF = 5;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Bit offset of the k-th n-bit coefficient inside a packed vector.
    function automatic int unsigned coef_lsb(input int unsigned k, input int unsigned n);
        return k * n;
    endfunction

endpackage

// File: rtl/poly_coef_deser.sv
// Indexed coefficient write register: one N-bit coefficient is written
// per enabled cycle at position wr_idx; all other coefficients hold.
module poly_coef_deser
    import poly_mult_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int N  = N_DEF,
    parameter int IW = (D > 1) ? $clog2(D) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [N-1:0]    wr_data,
    output logic [D*N-1:0]  vec
);

    logic [D*N-1:0] vec_r;

    // Write the addressed coefficient, otherwise hold the whole operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_r <= {(D*N){1'b0}};
        end else if (wr_en) begin
            vec_r[coef_lsb(32'(wr_idx), N) +: N] <= wr_data;
        end else begin
            vec_r <= vec_r;
        end
    end

    assign vec = vec_r;

endmodule

// File: rtl/poly_mult_ctrl.sv
// Operand sequencer and result collector for the negacyclic poly-mult
// systolic array. Loads a then b serially, holds them stable for the
// array latency, captures the product and streams it out coefficient
// by coefficient.
// Optional build macro POLY_MULT_CTRL_KEEP_B_EN adds a b_keep input that
// skips LOAD_B and reuses the previously loaded b operand.
module poly_mult_ctrl
    import poly_mult_pkg::*;
#(
    parameter int D   = D_DEF,
    parameter int N   = N_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
`ifdef POLY_MULT_CTRL_KEEP_B_EN
    input  logic            b_keep,
`endif
    output logic [D*N-1:0]  horz_o,
    output logic [D*N-1:0]  vert_o,
    input  logic [D*N-1:0]  p_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic            out_last,
    output logic            busy
);

    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int LW = $clog2(LAT + 1);

    state_t          state_r, state_s;
    logic [IW-1:0]   idx_r, idx_s;
    logic [LW-1:0]   lcnt_r, lcnt_s;
    logic [D*N-1:0]  result_r, result_s;
    logic            wr_a_s, wr_b_s;
    logic            in_hs_s, out_hs_s, keep_s;

    logic            in_ready_r, in_ready_s;
    logic            out_valid_r, out_valid_s;
    logic [N-1:0]    out_data_r, out_data_s;
    logic            out_last_r, out_last_s;
    logic            busy_r, busy_s;

`ifdef POLY_MULT_CTRL_KEEP_B_EN
    assign keep_s = b_keep;
`else
    assign keep_s = 1'b0;
`endif

    assign in_hs_s  = in_valid && in_ready_r;
    assign out_hs_s = out_valid_r && out_ready;

    poly_coef_deser #(.D(D), .N(N), .IW(IW)) u_deser_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_a_s),
        .wr_idx  (idx_r),
        .wr_data (in_data),
        .vec     (horz_o)
    );

    poly_coef_deser #(.D(D), .N(N), .IW(IW)) u_deser_b (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_b_s),
        .wr_idx  (idx_r),
        .wr_data (in_data),
        .vec     (vert_o)
    );

    // Next-state, counter and capture logic; outputs are derived from the
    // next state so they can be registered without an extra cycle.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        lcnt_s   = lcnt_r;
        result_s = result_r;
        wr_a_s   = 1'b0;
        wr_b_s   = 1'b0;
        case (state_r)
            LOAD_A: begin
                if (in_hs_s) begin
                    wr_a_s = 1'b1;
                    if (idx_r == IW'(D - 1)) begin
                        idx_s   = {IW{1'b0}};
                        lcnt_s  = {LW{1'b0}};
                        state_s = keep_s ? RUN : LOAD_B;
                    end else begin
                        idx_s = idx_r + IW'(1);
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            LOAD_B: begin
                if (in_hs_s) begin
                    wr_b_s = 1'b1;
                    if (idx_r == IW'(D - 1)) begin
                        idx_s   = {IW{1'b0}};
                        lcnt_s  = {LW{1'b0}};
                        state_s = RUN;
                    end else begin
                        idx_s = idx_r + IW'(1);
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            RUN: begin
                if (lcnt_r == LW'(LAT - 1)) begin
                    result_s = p_i;
                    idx_s    = {IW{1'b0}};
                    lcnt_s   = {LW{1'b0}};
                    state_s  = DRAIN;
                end else begin
                    lcnt_s = lcnt_r + LW'(1);
                end
            end
            DRAIN: begin
                if (out_hs_s) begin
                    if (idx_r == IW'(D - 1)) begin
                        idx_s   = {IW{1'b0}};
                        state_s = LOAD_A;
                    end else begin
                        idx_s = idx_r + IW'(1);
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                state_s = LOAD_A;
                idx_s   = {IW{1'b0}};
                lcnt_s  = {LW{1'b0}};
            end
        endcase

        in_ready_s  = (state_s == LOAD_A) || (state_s == LOAD_B);
        busy_s      = !((state_s == LOAD_A) && (idx_s == {IW{1'b0}}));
        out_valid_s = (state_s == DRAIN);
        if (state_s == DRAIN) begin
            out_data_s = result_s[coef_lsb(32'(idx_s), N) +: N];
            out_last_s = (idx_s == IW'(D - 1));
        end else begin
            out_data_s = {N{1'b0}};
            out_last_s = 1'b0;
        end
    end

    // State, counters, result and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= LOAD_A;
            idx_r       <= {IW{1'b0}};
            lcnt_r      <= {LW{1'b0}};
            result_r    <= {(D*N){1'b0}};
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {N{1'b0}};
            out_last_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            lcnt_r      <= lcnt_s;
            result_r    <= result_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_last_r  <= out_last_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_poly_mult_ctrl.sv
// Self-checking bench for poly_mult_ctrl with an attached negacyclic
// array model (LAT-1 register stages after the operand inputs).
module tb_poly_mult_ctrl;

    localparam int D   = 4;
    localparam int N   = 4;
    localparam int LAT = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_data;
`ifdef POLY_MULT_CTRL_KEEP_B_EN
    logic            b_keep;
`endif
    logic [D*N-1:0]  horz_o, vert_o, p_i;
    logic            out_valid, out_ready, out_last, busy;
    logic [N-1:0]    out_data;

    poly_mult_ctrl #(.D(D), .N(N), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef POLY_MULT_CTRL_KEEP_B_EN
        .b_keep    (b_keep),
`endif
        .horz_o    (horz_o),
        .vert_o    (vert_o),
        .p_i       (p_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Array model: negacyclic product mod x^D+1, coefficients mod 2^N.
    function automatic logic [D*N-1:0] negacyc(input logic [D*N-1:0] a, input logic [D*N-1:0] b);
        logic [N-1:0]   acc [D];
        logic [2*N-1:0] pr;
        logic [D*N-1:0] r;
        for (int k = 0; k < D; k++) acc[k] = '0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                pr = a[N*i +: N] * b[N*j +: N];
                if (i + j < D) acc[i+j]   = acc[i+j] + pr[N-1:0];
                else           acc[i+j-D] = acc[i+j-D] - pr[N-1:0];
            end
        end
        for (int k = 0; k < D; k++) r[N*k +: N] = acc[k];
        return r;
    endfunction

    logic [D*N-1:0] pipe [LAT-1];
    always @(posedge clk) begin
        pipe[0] <= negacyc(horz_o, vert_o);
        for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign p_i = pipe[LAT-2];

    typedef struct {
        logic [D*N-1:0] a, b, e;
        bit keep, gaps, stall;
    } rec_t;

    typedef struct packed {
        logic [N-1:0] d;
        logic         l;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0;
    int cyc = 0, last_hs_cyc = 0;
    int in_beats = 0, out_beats = 0;
    bit hs_seen = 1'b0, prev_valid = 1'b0, prev_stall = 1'b0;
    logic [N-1:0] held_d;
    logic         held_l;

    function automatic logic [D*N-1:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {c3[N-1:0], c2[N-1:0], c1[N-1:0], c0[N-1:0]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: monitor/scoreboard at the negedge, then the active edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        hs_seen = in_valid && in_ready;
        if (!rst) begin
            if (hs_seen) begin
                last_hs_cyc = cyc;
                in_beats++;
            end
            if (out_valid && !prev_valid) chk("latency", cyc - last_hs_cyc, LAT + 1);
            if (out_valid) chk("in_ready_low", int'(in_ready), 0);
            if (out_valid && prev_stall) begin
                chk("stall_data", int'(out_data), int'(held_d));
                chk("stall_last", int'(out_last), int'(held_l));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", int'(out_data), -1);
                end else begin
                    e = q.pop_front();
                    chk("out_data", int'(out_data), int'(e.d));
                    chk("out_last", int'(out_last), int'(e.l));
                end
                out_beats++;
            end
            prev_stall = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
        end else begin
            prev_stall = 1'b0;
        end
        prev_valid = out_valid;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Push expected results and feed up to nlim input beats.
    task automatic load_op(input rec_t r, input int nlim);
        int nb, guard;
        exp_t e;
        in_beats  = 0;
        out_beats = 0;
        for (int k = 0; k < D; k++) begin
            e.d = r.e[N*k +: N];
            e.l = (k == D - 1);
            q.push_back(e);
        end
        nb = r.keep ? D : 2 * D;
        if (nlim < nb) nb = nlim;
        for (int i = 0; i < nb; i++) begin
            if (r.gaps) repeat ($urandom_range(0, 2)) step();
            in_valid = 1'b1;
            in_data  = (i < D) ? r.a[N*i +: N] : r.b[N*(i-D) +: N];
`ifdef POLY_MULT_CTRL_KEEP_B_EN
            b_keep = r.keep && (i == D - 1);
`endif
            guard = 0;
            step();
            while (!hs_seen && guard < 50) begin
                step();
                guard++;
            end
            chk("in_accept", int'(hs_seen), 1);
            in_valid = 1'b0;
`ifdef POLY_MULT_CTRL_KEEP_B_EN
            b_keep = 1'b0;
`endif
        end
    endtask

    // Collect the result stream, optionally with a 3-cycle stall mid-drain.
    task automatic drain_op(input rec_t r);
        int guard = 0, stall_left = 3;
        while (q.size() != 0 && guard < 200) begin
            if (r.stall && out_beats == 2 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            step();
            guard++;
        end
        out_ready = 1'b1;
        chk("drain_left", q.size(), 0);
        chk("in_beats", in_beats, r.keep ? D : 2 * D);
        chk("idle_busy", int'(busy), 0);
        chk("idle_in_ready", int'(in_ready), 1);
    endtask

    rec_t tbl [8];
    rec_t rv;

    initial begin
        tbl[0] = '{a: pk(1,0,0,0),   b: pk(1,2,3,4),     e: pk(1,2,3,4),     keep: 0, gaps: 0, stall: 0};
        tbl[1] = '{a: pk(0,1,0,0),   b: pk(1,2,3,4),     e: pk(12,1,2,3),    keep: 0, gaps: 0, stall: 0};
        tbl[2] = '{a: pk(0,0,0,1),   b: pk(1,2,3,4),     e: pk(14,13,12,1),  keep: 0, gaps: 1, stall: 0};
        tbl[3] = '{a: pk(1,1,0,0),   b: pk(1,1,0,0),     e: pk(1,2,1,0),     keep: 0, gaps: 0, stall: 1};
        tbl[4] = '{a: pk(15,0,0,0),  b: pk(15,15,15,15), e: pk(1,1,1,1),     keep: 0, gaps: 1, stall: 1};
        tbl[5] = '{a: pk(2,0,0,0),   b: pk(0,0,0,8),     e: pk(0,0,0,0),     keep: 0, gaps: 0, stall: 0};
        tbl[6] = '{a: pk(0,0,1,0),   b: pk(0,0,1,0),     e: pk(15,0,0,0),    keep: 0, gaps: 1, stall: 0};
        tbl[7] = '{a: pk(1,2,3,4),   b: pk(1,2,3,4),     e: pk(8,12,10,4),   keep: 0, gaps: 1, stall: 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef POLY_MULT_CTRL_KEEP_B_EN
        b_keep    = 1'b0;
`endif
        step();
        step();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_horz", int'(horz_o), 0);
        chk("rst_vert", int'(vert_o), 0);
        rst = 1'b0;

        for (int t = 0; t < 8; t++) begin
            load_op(tbl[t], 2 * D);
            drain_op(tbl[t]);
        end

        // Reset after 5 of 8 input beats, then a fresh full load.
        rv = '{a: pk(3,5,7,9), b: pk(11,6,2,13), e: pk(0,0,0,0), keep: 0, gaps: 0, stall: 0};
        load_op(rv, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        chk("mid_load_in_ready", int'(in_ready), 1);
        chk("mid_load_busy", int'(busy), 0);
        chk("mid_load_horz", int'(horz_o), 0);
        chk("mid_load_vert", int'(vert_o), 0);
        load_op(tbl[1], 2 * D);
        drain_op(tbl[1]);

        // Reset during DRAIN after two result beats.
        load_op(tbl[7], 2 * D);
        begin
            int guard = 0;
            out_ready = 1'b1;
            while (out_beats < 2 && guard < 100) begin
                step();
                guard++;
            end
        end
        chk("mid_drain_beats", out_beats, 2);
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        chk("mid_drain_valid", int'(out_valid), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_rst_valid", int'(out_valid), 0);
        end
        chk("post_rst_busy", int'(busy), 0);

`ifdef POLY_MULT_CTRL_KEEP_B_EN
        load_op(tbl[0], 2 * D);
        drain_op(tbl[0]);
        rv = '{a: pk(0,1,0,0), b: pk(0,0,0,0), e: pk(12,1,2,3), keep: 1, gaps: 0, stall: 0};
        load_op(rv, 2 * D);
        drain_op(rv);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
